// File: rtl/ramarb.sv
// ramarb -- two-master arbiter in front of a single pipelined SRAM controller.
//
// Master 0 (video fetch) and master 1 (CPU) share one slave port. A master
// owns the slave from the cycle after it is granted until it has dropped its
// cycle and every accepted request has been acknowledged. Ties in IDLE go to
// the master that did not win last. Requests, write data and acks pass
// straight through (no added latency). An outstanding-transfer counter
// throttles the owner once 2^CNT_W-1 requests are in flight.
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   m0_* / m1_*               master-side bus: cyc/stb/we/sel/adr/dat in,
//                             ack/stall/dat out
//   s_*                       slave-side bus to the SRAM controller:
//                             cyc/stb/we/sel/adr/dat out, ack/stall/dat in
module ramarb #(
    parameter int CNT_W = 2,
    parameter int ADR_W = 19
) (
    input  logic             clk_i,
    input  logic             reset_i,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [1:0]       m0_sel_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [15:0]      m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_stall_o,
    output logic [15:0]      m0_dat_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [1:0]       m1_sel_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [15:0]      m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_stall_o,
    output logic [15:0]      m1_dat_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [1:0]       s_sel_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [15:0]      s_dat_o,
    input  logic             s_ack_i,
    input  logic             s_stall_i,
    input  logic [15:0]      s_dat_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    // Index of the master that owned the bus most recently; reset to 1 so
    // master 0 wins the first tie.
    logic             last_win, last_win_nxt;
    logic [CNT_W-1:0] count, count_nxt;

    logic             cnt_zero;
    logic             cnt_full;
    logic             accept;
    logic             ack_fwd;

    assign cnt_zero = (count == '0);
    assign cnt_full = (count == CNT_MAX);

    // Read data is broadcast; only the owner sees an ack, so the other
    // master ignores it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            count    <= '0;
            last_win <= 1'b1;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            last_win <= last_win_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_win_nxt = last_win;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_sel_o      = '0;
        s_adr_o      = '0;
        s_dat_o      = '0;
        m0_stall_o   = 1'b1;
        m1_stall_o   = 1'b1;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        accept       = 1'b0;
        ack_fwd      = 1'b0;

        case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_win)) begin
                    state_nxt = OWN0;
                end else if (m1_cyc_i) begin
                    state_nxt = OWN1;
                end
            end

            OWN0: begin
                s_cyc_o    = m0_cyc_i || !cnt_zero;
                s_stb_o    = m0_stb_i && m0_cyc_i && !cnt_full;
                s_we_o     = m0_we_i;
                s_sel_o    = m0_sel_i;
                s_adr_o    = m0_adr_i;
                s_dat_o    = m0_dat_i;
                m0_stall_o = s_stall_i || cnt_full;
                // An ack with nothing outstanding is stray and is dropped.
                m0_ack_o   = s_ack_i && !cnt_zero;
                accept     = m0_stb_i && m0_cyc_i && !cnt_full && !s_stall_i;
                ack_fwd    = s_ack_i && !cnt_zero;
                if (!m0_cyc_i && cnt_zero) begin
                    state_nxt    = IDLE;
                    last_win_nxt = 1'b0;
                end
            end

            OWN1: begin
                s_cyc_o    = m1_cyc_i || !cnt_zero;
                s_stb_o    = m1_stb_i && m1_cyc_i && !cnt_full;
                s_we_o     = m1_we_i;
                s_sel_o    = m1_sel_i;
                s_adr_o    = m1_adr_i;
                s_dat_o    = m1_dat_i;
                m1_stall_o = s_stall_i || cnt_full;
                m1_ack_o   = s_ack_i && !cnt_zero;
                accept     = m1_stb_i && m1_cyc_i && !cnt_full && !s_stall_i;
                ack_fwd    = s_ack_i && !cnt_zero;
                if (!m1_cyc_i && cnt_zero) begin
                    state_nxt    = IDLE;
                    last_win_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The full-count stall keeps accept low at CNT_MAX and ack_fwd is
        // low at zero, so the counter can neither wrap nor underflow.
        count_nxt = count;
        if (accept && !ack_fwd) begin
            count_nxt = count + CNT_W'(1);
        end else if (!accept && ack_fwd) begin
            count_nxt = count - CNT_W'(1);
        end
    end

endmodule

// File: doc/ramarb.md
RAMARB -- requirements
Module: ramarb

Interface
REQ-001 Parameter: CNT_W, 2, width of the outstanding-transfer counter; the maximum outstanding count is 2^CNT_W-1.
REQ-002 Parameter: ADR_W, 19, word address width, matching the SRAM controller address bus [19:1].
REQ-003 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_i  in  1  asynchronous, active-high reset.
REQ-005 Port: m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (video fetch) bus cycle, strobe and write-enable.
REQ-006 Port: m0_sel_i  in  2  master 0 byte lane selects.
REQ-007 Port: m0_adr_i  in  ADR_W  master 0 address.
REQ-008 Port: m0_dat_i  in  16  master 0 write data.
REQ-009 Port: m0_ack_o, m0_stall_o  out  1 each  master 0 acknowledge and stall.
REQ-010 Port: m0_dat_o  out  16  master 0 read data.
REQ-011 Port: m1_* (master 1, CPU), identical set to REQ-005..REQ-010.
REQ-012 Port: s_cyc_o, s_stb_o, s_we_o  out  1 each  to the SRAM controller.
REQ-013 Port: s_sel_o  out  2  byte lane selects to the SRAM controller.
REQ-014 Port: s_adr_o  out  ADR_W  address to the SRAM controller.
REQ-015 Port: s_dat_o  out  16  write data to the SRAM controller.
REQ-016 Port: s_ack_i, s_stall_i  in  1 each  acknowledge and stall from the SRAM controller.
REQ-017 Port: s_dat_i  in  16  read data from the SRAM controller.

Function
REQ-018 FSM states: IDLE, OWN0, OWN1; state, last-winner bit and outstanding counter are registered.
REQ-019 IDLE: s_cyc_o=0, s_stb_o=0, both m*_stall_o=1, both m*_ack_o=0.
REQ-020 IDLE, only mN_cyc_i=1 -> OWNN next cycle.
REQ-021 IDLE, both cyc high -> grant the master that did not win last; after reset master 0 wins the first tie.
REQ-022 OWNN: s_we/sel/adr/dat_o = master N's inputs; s_cyc_o = mN_cyc_i OR (count != 0).
REQ-023 OWNN: s_stb_o = mN_stb_i AND mN_cyc_i AND (count != max).
REQ-024 OWNN: mN_stall_o = s_stall_i OR (count == max); the non-owner's stall_o=1 and ack_o=0.
REQ-025 OWNN: mN_ack_o = s_ack_i (combinational); both m*_dat_o = s_dat_i at all times.
REQ-026 Counter: +1 on (s_stb_o AND NOT s_stall_i) without s_ack_i; -1 on s_ack_i without an accept; unchanged when both occur in the same cycle.
REQ-027 Counter never wraps: the count==max stall prevents overflow; s_ack_i at count 0 is ignored (no underflow, no ack forwarded).
REQ-028 OWNN -> IDLE when mN_cyc_i=0 AND count==0 (sampled that cycle); last-winner updated to N; re-arbitration occurs in the following IDLE cycle, i.e. at least one idle cycle between owners.
REQ-029 Owner drops cyc while count>0: ownership is held, s_stb_o=0, s_cyc_o=1 until drained; draining acks are still forwarded to the owner.
REQ-030 The non-owner's requests never reach s_*; ownership is not preempted.
REQ-031 Write data/address are not registered; the block adds zero cycles of request or ack latency in OWNN.

Reset
REQ-032 reset_i asserted -> immediately: state=IDLE, count=0, last-winner=1 (master 0 wins the next tie); all outputs take their IDLE values from REQ-019.
REQ-033 Reset mid-transfer discards outstanding acks; the SRAM controller is reset by the same reset_i.

Verification
REQ-034 m1 alone issues 3 reads, A=0x00010..0x00012, with a 2-cycle slave ack -> s_adr_o follows A, m1 sees 3 acks, count returns to 0, state returns to IDLE.
REQ-035 Both cyc rise the same cycle after reset -> OWN0 first; m1_stall_o=1 throughout; after m0 releases: IDLE one cycle, then OWN1.
REQ-036 CNT_W=2, slave never acks, m0 strobes continuously -> exactly 3 accepts, then m0_stall_o=1 and s_stb_o=0.
REQ-037 Accept and ack in the same cycle at count=1 -> count stays 1.
REQ-038 m0 drops cyc at count=2 -> s_cyc_o stays 1 and 2 acks are forwarded to m0; IDLE is entered only after the second ack.
REQ-039 reset_i pulsed mid-burst at count=2 -> all outputs are at IDLE values in the same cycle; later acks are not forwarded.
